// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add/subtract sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/fulladder.sv
// One-bit full-adder cell used as the serial arithmetic slice.
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract: one full-adder slice, LSB first, WIDTH+1-bit result
// returned over a valid/ready handshake.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  seq_state_t       state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q;
  logic [WIDTH-1:0] s_sh_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, sub_q;
  logic             s_bit, carry_d;

  fulladder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .c_i  (carry_q),
    .s_o  (s_bit),
    .co_o (carry_d)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in natural order.
  assign s_sh_d = (s_sh_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= in_a;
            b_sh_q  <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub;
            sub_q   <= in_sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // For subtraction the final carry is "no borrow"; invert it to get bit WIDTH.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = (state_q == DONE) ? {sub_q ? ~carry_q : carry_q, s_sh_q} : '0;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: vector table, back-pressure, reset abort,
// streaming throughput, and a WIDTH=1 instance.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_sub, out_valid, out_ready, busy;
  logic [7:0] in_a, in_b;
  logic [8:0] out_sum;

  logic       in_valid1, in_ready1, in_sub1, out_valid1, out_ready1, busy1;
  logic [0:0] in_a1, in_b1;
  logic [1:0] out_sum1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  serial_add_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [8:0] za, zb;
    za = {1'b0, a};
    zb = {1'b0, b};
    return sub ? (za - zb) : (za + zb);
  endfunction

  // Issue one op, check latency (result in cycle 9), value, and release.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic [8:0] exp, input string name);
    int lat;
    check({name, "_in_ready"}, in_ready, 1);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_sub = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 9);
    check({name, "_sum"}, out_sum, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_released"}, {out_valid, busy, in_ready}, 3'b001);
  endtask

  task automatic run_op1(input logic a, input logic b, input logic sub,
                         input logic [1:0] exp, input string name);
    int lat;
    in_a1 = a; in_b1 = b; in_sub1 = sub; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 2);
    check({name, "_sum"}, out_sum1, exp);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check({name, "_released"}, {out_valid1, in_ready1}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] expq[$];
    logic [8:0] held;
    int         accepts, last_acc, cyc, seen;
    logic       acc_prev;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 9'h096, "add_5a_3c"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01"};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE, "add_ff_ff"};
    vecs[3] = '{8'h20, 8'h10, 1'b1, 9'h010, "sub_20_10"};
    vecs[4] = '{8'h10, 8'h20, 1'b1, 9'h1F0, "sub_10_20"};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 9'h000, "sub_00_00"};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 9'h000, "add_00_00"};
    vecs[7] = '{8'h80, 8'h01, 1'b1, 9'h07F, "sub_80_01"};
    vecs[8] = '{8'h01, 8'hFF, 1'b1, 9'h102, "sub_01_ff"};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_sub1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {out_valid, busy, in_ready}, 3'b000);
    check("rst_sum", out_sum, 9'h000);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_state", {out_valid, busy, out_sum}, 11'h000);
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp, vecs[i].name);

    // Back-pressure: result holds, extra request pulses are ignored.
    in_a = 8'h33; in_b = 8'h44; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", cyc, 9);
    held = out_sum;
    check("bp_sum", held, 9'h077);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0);
      in_a = 8'h11; in_b = 8'h22; in_sub = 1'b1;
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, out_sum}, {1'b1, 1'b0, 9'h077});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_consumed", {out_valid, busy, in_ready}, 3'b001);
    repeat (12) @(negedge clk);
    check("bp_no_extra", {out_valid, busy}, 2'b00);

    // Reset in the 4th RUN cycle aborts the operation.
    in_a = 8'hAA; in_b = 8'h55; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_state", {busy, out_valid, in_ready}, 3'b000);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    run_op(8'h01, 8'h02, 1'b0, 9'h003, "after_abort");

    // Streaming: one accept every 10 cycles, results match the model.
    out_ready = 1'b1;
    in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
    in_valid = 1'b1;
    accepts = 0; last_acc = -1; acc_prev = 1'b0;
    for (cyc = 0; cyc < 80; cyc++) begin
      if (acc_prev) begin
        in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom);
      end
      acc_prev = 1'b0;
      if (out_valid) begin
        if (expq.size() == 0) check("stream_unexpected", 1, 0);
        else check("stream_sum", out_sum, expq.pop_front());
      end
      if (in_ready && accepts < 6) begin
        expq.push_back(model(in_a, in_b, in_sub));
        if (last_acc >= 0) check("stream_interval", cyc - last_acc, 10);
        last_acc = cyc;
        accepts++;
        acc_prev = 1'b1;
        if (accepts == 6) begin
          @(negedge clk);
          in_valid = 1'b0;
          continue;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_accepts", accepts, 6);
    check("stream_drained", expq.size(), 0);

    run_op1(1'b1, 1'b1, 1'b0, 2'b10, "w1_add_1_1");
    run_op1(1'b0, 1'b1, 1'b1, 2'b11, "w1_sub_0_1");
    run_op1(1'b1, 1'b0, 1'b1, 2'b01, "w1_sub_1_0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
